// File: rtl/timer_sched_pkg.sv
// Shared constants, slot-state record and delay clamp helper for the timer slot scheduler.
package timer_sched_pkg;

    localparam logic [31:0] DELAY_CLAMP = 32'h7FFF_FFFF;
    localparam int          PRESCALE_W  = 16;

    typedef struct packed {
        logic [31:0] deadline;
        logic [31:0] period;
        logic        periodic;
        logic        active;
        logic        pending;
        logic        overrun;
    } slot_state_t;

    // Keeps every deadline within half the counter range so the sign-bit compare stays valid.
    function automatic logic [31:0] clamp_delay(input logic [31:0] delay);
        return (delay > DELAY_CLAMP) ? DELAY_CLAMP : delay;
    endfunction

endpackage

// File: rtl/timer_sched_rr_arbiter.sv
// Round-robin priority picker: grants the first set request at or after ptr, wrapping around.
module timer_sched_rr_arbiter
    import timer_sched_pkg::*;
#(
    parameter int NUM_SLOTS = 4,
    parameter int SLOT_W    = 2
) (
    input  logic [NUM_SLOTS-1:0] req,
    input  logic [SLOT_W-1:0]    ptr,
    output logic [SLOT_W-1:0]    grant,
    output logic                 any
);

    logic [SLOT_W-1:0] cand;

    always_comb begin
        grant = '0;
        any   = 1'b0;
        cand  = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            cand = SLOT_W'((int'(ptr) + i) % NUM_SLOTS);
            if (!any && req[cand]) begin
                grant = cand;
                any   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/timer_slot_scheduler.sv
// Multi-slot deadline scheduler on a shared prescaled tick counter, with wrap-safe expiry
// detection and round-robin delivery of expiry events over a valid/ready port.
module timer_slot_scheduler
    import timer_sched_pkg::*;
#(
    parameter int NUM_SLOTS = 4,
    parameter int SLOT_W    = 2
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  cfg_enable,
    input  logic [15:0]           cfg_prescale,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [SLOT_W-1:0]     req_slot,
    input  logic                  req_cancel,
    input  logic                  req_periodic,
    input  logic [31:0]           req_delay,
    output logic                  evt_valid,
    output logic [SLOT_W-1:0]     evt_slot,
    output logic                  evt_overrun,
    input  logic                  evt_ready,
    output logic [31:0]           now,
    output logic [NUM_SLOTS-1:0]  active,
    output logic [NUM_SLOTS-1:0]  pending
);

    logic [PRESCALE_W-1:0] pcnt_q, pcnt_d;
    logic [31:0]           now_q, now_d;
    logic [SLOT_W-1:0]     rr_ptr_q, rr_ptr_d;
    slot_state_t           slot_q [NUM_SLOTS];
    slot_state_t           slot_d [NUM_SLOTS];

    logic [31:0]           lag [NUM_SLOTS];
    logic [NUM_SLOTS-1:0]  expired;
    logic [NUM_SLOTS-1:0]  overrun_vec;
    logic [31:0]           arm_delay;
    logic [31:0]           arm_period;
    logic                  req_fire;
    logic                  evt_fire;
    logic [SLOT_W-1:0]     grant;
    logic                  grant_any;

    assign req_ready = !sys_rst;
    assign req_fire  = req_valid && req_ready;
    assign evt_fire  = evt_valid && evt_ready;
    assign now       = now_q;

    always_comb begin
        for (int s = 0; s < NUM_SLOTS; s++) begin
            active[s]      = slot_q[s].active;
            pending[s]     = slot_q[s].pending;
            overrun_vec[s] = slot_q[s].overrun;
        end
    end

    timer_sched_rr_arbiter #(
        .NUM_SLOTS (NUM_SLOTS),
        .SLOT_W    (SLOT_W)
    ) u_arbiter (
        .req   (pending),
        .ptr   (rr_ptr_q),
        .grant (grant),
        .any   (grant_any)
    );

    assign evt_valid   = grant_any;
    assign evt_slot    = grant;
    assign evt_overrun = overrun_vec[grant];

    always_comb begin
        pcnt_d = pcnt_q;
        now_d  = now_q;
        if (cfg_enable) begin
            if (pcnt_q == cfg_prescale) begin
                pcnt_d = '0;
                now_d  = now_q + 32'd1;
            end else begin
                pcnt_d = pcnt_q + PRESCALE_W'(1);
            end
        end
    end

    // Expired means now has reached or passed the deadline, judged by the sign of the difference.
    always_comb begin
        for (int s = 0; s < NUM_SLOTS; s++) begin
            lag[s]     = now_q - slot_q[s].deadline;
            expired[s] = slot_q[s].active && !lag[s][31];
        end
    end

    assign arm_delay  = clamp_delay(req_delay);
    assign arm_period = (arm_delay == 32'd0) ? 32'd1 : arm_delay;

    // Priority within one cycle: handshake clear, then expiry, then a request to the same slot.
    always_comb begin
        for (int s = 0; s < NUM_SLOTS; s++) begin
            slot_d[s] = slot_q[s];
            if (evt_fire && grant == SLOT_W'(s)) begin
                slot_d[s].pending = 1'b0;
                slot_d[s].overrun = 1'b0;
            end
            if (expired[s]) begin
                slot_d[s].pending = 1'b1;
                if (slot_q[s].pending && !(evt_fire && grant == SLOT_W'(s))) begin
                    slot_d[s].overrun = 1'b1;
                end
                if (slot_q[s].periodic) begin
                    slot_d[s].deadline = slot_q[s].deadline + slot_q[s].period;
                end else begin
                    slot_d[s].active = 1'b0;
                end
            end
            if (req_fire && req_slot == SLOT_W'(s)) begin
                slot_d[s].active  = !req_cancel;
                slot_d[s].pending = 1'b0;
                slot_d[s].overrun = 1'b0;
                if (!req_cancel) begin
                    slot_d[s].deadline = now_q + arm_delay;
                    slot_d[s].period   = arm_period;
                    slot_d[s].periodic = req_periodic;
                end
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (evt_fire) begin
            rr_ptr_d = (grant == SLOT_W'(NUM_SLOTS - 1)) ? '0 : grant + SLOT_W'(1);
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            pcnt_q   <= '0;
            now_q    <= '0;
            rr_ptr_q <= '0;
            for (int s = 0; s < NUM_SLOTS; s++) begin
                slot_q[s] <= '0;
            end
        end else begin
            pcnt_q   <= pcnt_d;
            now_q    <= now_d;
            rr_ptr_q <= rr_ptr_d;
            for (int s = 0; s < NUM_SLOTS; s++) begin
                slot_q[s] <= slot_d[s];
            end
        end
    end

endmodule

// File: tb/tb_timer_slot_scheduler.sv
// Directed scenario bench for timer_slot_scheduler; every expected value is hand-derived.
module tb_timer_slot_scheduler;

    localparam int NUM_SLOTS = 4;
    localparam int SLOT_W    = 2;

    logic                 sys_clk;
    logic                 sys_rst;
    logic                 cfg_enable;
    logic [15:0]          cfg_prescale;
    logic                 req_valid;
    logic                 req_ready;
    logic [SLOT_W-1:0]    req_slot;
    logic                 req_cancel;
    logic                 req_periodic;
    logic [31:0]          req_delay;
    logic                 evt_valid;
    logic [SLOT_W-1:0]    evt_slot;
    logic                 evt_overrun;
    logic                 evt_ready;
    logic [31:0]          now;
    logic [NUM_SLOTS-1:0] active;
    logic [NUM_SLOTS-1:0] pending;

    int checks = 0;
    int passed = 0;

    timer_slot_scheduler #(
        .NUM_SLOTS (NUM_SLOTS),
        .SLOT_W    (SLOT_W)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .cfg_enable   (cfg_enable),
        .cfg_prescale (cfg_prescale),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_slot     (req_slot),
        .req_cancel   (req_cancel),
        .req_periodic (req_periodic),
        .req_delay    (req_delay),
        .evt_valid    (evt_valid),
        .evt_slot     (evt_slot),
        .evt_overrun  (evt_overrun),
        .evt_ready    (evt_ready),
        .now          (now),
        .active       (active),
        .pending      (pending)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Inputs change and outputs are sampled on the falling edge, away from the active edge.
    task automatic step(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic do_reset();
        sys_rst   = 1'b1;
        req_valid = 1'b0;
        evt_ready = 1'b0;
        step(2);
        sys_rst = 1'b0;
    endtask

    task automatic send_req(input logic [SLOT_W-1:0] slot, input logic cancel,
                            input logic periodic, input logic [31:0] delay);
        req_valid    = 1'b1;
        req_slot     = slot;
        req_cancel   = cancel;
        req_periodic = periodic;
        req_delay    = delay;
        step(1);
        req_valid    = 1'b0;
        req_cancel   = 1'b0;
        req_periodic = 1'b0;
        req_delay    = 32'd0;
    endtask

    task automatic test_reset();
        sys_rst = 1'b1;
        step(2);
        checks++; if (now !== 32'd0) $display("[TB] FAIL reset_now: got %0h want 0", now); else passed++;
        checks++; if (active !== 4'b0000) $display("[TB] FAIL reset_active: got %b want 0000", active); else passed++;
        checks++; if (pending !== 4'b0000) $display("[TB] FAIL reset_pending: got %b want 0000", pending); else passed++;
        checks++; if (evt_valid !== 1'b0 || evt_slot !== 2'd0 || evt_overrun !== 1'b0)
            $display("[TB] FAIL reset_evt: got v=%b s=%0d o=%b want 0/0/0", evt_valid, evt_slot, evt_overrun); else passed++;
        checks++; if (req_ready !== 1'b0) $display("[TB] FAIL reset_req_ready: got %b want 0", req_ready); else passed++;
        sys_rst = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b1) $display("[TB] FAIL run_req_ready: got %b want 1", req_ready); else passed++;
    endtask

    task automatic test_oneshot();
        do_reset();
        send_req(2'd1, 1'b0, 1'b0, 32'd10);
        step(9);
        checks++; if (now !== 32'd10) $display("[TB] FAIL oneshot_now10: got %0d want 10", now); else passed++;
        checks++; if (pending !== 4'b0000) $display("[TB] FAIL oneshot_early: got %b want 0000", pending); else passed++;
        step(1);
        checks++; if (pending !== 4'b0010 || evt_valid !== 1'b1 || evt_slot !== 2'd1)
            $display("[TB] FAIL oneshot_fire: got p=%b v=%b s=%0d want 0010/1/1", pending, evt_valid, evt_slot); else passed++;
        checks++; if (active !== 4'b0000) $display("[TB] FAIL oneshot_disarm: got %b want 0000", active); else passed++;
        evt_ready = 1'b1;
        step(1);
        evt_ready = 1'b0;
        checks++; if (pending !== 4'b0000 || evt_valid !== 1'b0)
            $display("[TB] FAIL oneshot_take: got p=%b v=%b want 0000/0", pending, evt_valid); else passed++;
    endtask

    task automatic test_wrap();
        do_reset();
        cfg_enable = 1'b0;
        force dut.now_q = 32'hFFFF_FFF0;
        step(1);
        release dut.now_q;
        checks++; if (now !== 32'hFFFF_FFF0) $display("[TB] FAIL wrap_preset: got %h want fffffff0", now); else passed++;
        cfg_enable = 1'b1;
        send_req(2'd0, 1'b0, 1'b0, 32'h20);
        step(15);
        checks++; if (pending !== 4'b0000) $display("[TB] FAIL wrap_at_zero: got %b want 0000", pending); else passed++;
        step(16);
        checks++; if (now !== 32'h10 || pending !== 4'b0000)
            $display("[TB] FAIL wrap_deadline: got now=%h p=%b want 10/0000", now, pending); else passed++;
        step(1);
        checks++; if (pending !== 4'b0001 || evt_slot !== 2'd0 || now !== 32'h11)
            $display("[TB] FAIL wrap_fire: got p=%b s=%0d now=%h want 0001/0/11", pending, evt_slot, now); else passed++;
        evt_ready = 1'b1;
        step(1);
        evt_ready = 1'b0;
    endtask

    task automatic test_periodic_overrun();
        do_reset();
        send_req(2'd2, 1'b0, 1'b1, 32'd5);
        step(11);
        checks++; if (evt_valid !== 1'b1 || evt_slot !== 2'd2 || evt_overrun !== 1'b1)
            $display("[TB] FAIL periodic_overrun: got v=%b s=%0d o=%b want 1/2/1", evt_valid, evt_slot, evt_overrun); else passed++;
        checks++; if (active !== 4'b0100) $display("[TB] FAIL periodic_active: got %b want 0100", active); else passed++;
        evt_ready = 1'b1;
        step(1);
        evt_ready = 1'b0;
        checks++; if (pending !== 4'b0000 || evt_overrun !== 1'b0)
            $display("[TB] FAIL periodic_take: got p=%b o=%b want 0000/0", pending, evt_overrun); else passed++;
        step(2);
        checks++; if (pending !== 4'b0000) $display("[TB] FAIL periodic_early: got %b want 0000", pending); else passed++;
        step(1);
        checks++; if (pending !== 4'b0100 || evt_overrun !== 1'b0 || now !== 32'd16)
            $display("[TB] FAIL periodic_next: got p=%b o=%b now=%0d want 0100/0/16", pending, evt_overrun, now); else passed++;
        send_req(2'd2, 1'b1, 1'b0, 32'd0);
        checks++; if (active !== 4'b0000 || pending !== 4'b0000)
            $display("[TB] FAIL periodic_cancel: got a=%b p=%b want 0000/0000", active, pending); else passed++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        send_req(2'd0, 1'b0, 1'b0, 32'd6);
        send_req(2'd1, 1'b0, 1'b0, 32'd5);
        send_req(2'd3, 1'b0, 1'b0, 32'd4);
        step(3);
        checks++; if (pending !== 4'b0000) $display("[TB] FAIL rr_early: got %b want 0000", pending); else passed++;
        step(1);
        checks++; if (pending !== 4'b1011 || evt_slot !== 2'd0)
            $display("[TB] FAIL rr_first: got p=%b s=%0d want 1011/0", pending, evt_slot); else passed++;
        evt_ready = 1'b1;
        step(1);
        checks++; if (evt_valid !== 1'b1 || evt_slot !== 2'd1) $display("[TB] FAIL rr_second: got v=%b s=%0d want 1/1", evt_valid, evt_slot); else passed++;
        step(1);
        checks++; if (evt_valid !== 1'b1 || evt_slot !== 2'd3) $display("[TB] FAIL rr_third: got v=%b s=%0d want 1/3", evt_valid, evt_slot); else passed++;
        step(1);
        evt_ready = 1'b0;
        checks++; if (evt_valid !== 1'b0) $display("[TB] FAIL rr_drained: got %b want 0", evt_valid); else passed++;
        send_req(2'd0, 1'b0, 1'b0, 32'd0);
        checks++; if (pending !== 4'b0000) $display("[TB] FAIL zero_delay_early: got %b want 0000", pending); else passed++;
        step(1);
        checks++; if (pending !== 4'b0001) $display("[TB] FAIL zero_delay_fire: got %b want 0001", pending); else passed++;
        evt_ready = 1'b1;
        step(1);
        evt_ready = 1'b0;
        send_req(2'd0, 1'b0, 1'b0, 32'd3);
        send_req(2'd3, 1'b0, 1'b0, 32'd2);
        step(2);
        checks++; if (pending !== 4'b1001 || evt_slot !== 2'd3)
            $display("[TB] FAIL rr_wrap_first: got p=%b s=%0d want 1001/3", pending, evt_slot); else passed++;
        evt_ready = 1'b1;
        step(1);
        checks++; if (evt_valid !== 1'b1 || evt_slot !== 2'd0) $display("[TB] FAIL rr_wrap_second: got v=%b s=%0d want 1/0", evt_valid, evt_slot); else passed++;
        step(1);
        evt_ready = 1'b0;
    endtask

    task automatic test_cancel_rearm();
        do_reset();
        send_req(2'd1, 1'b0, 1'b0, 32'd5);
        step(4);
        send_req(2'd1, 1'b1, 1'b0, 32'd0);
        checks++; if (pending !== 4'b0000 || active !== 4'b0000)
            $display("[TB] FAIL cancel_race: got p=%b a=%b want 0000/0000", pending, active); else passed++;
        step(3);
        checks++; if (evt_valid !== 1'b0) $display("[TB] FAIL cancel_quiet: got %b want 0", evt_valid); else passed++;
        send_req(2'd1, 1'b0, 1'b0, 32'd3);
        send_req(2'd1, 1'b0, 1'b0, 32'd6);
        step(2);
        checks++; if (pending !== 4'b0000) $display("[TB] FAIL rearm_old_deadline: got %b want 0000", pending); else passed++;
        step(3);
        checks++; if (pending !== 4'b0000) $display("[TB] FAIL rearm_early: got %b want 0000", pending); else passed++;
        step(1);
        checks++; if (pending !== 4'b0010 || now !== 32'd17)
            $display("[TB] FAIL rearm_fire: got p=%b now=%0d want 0010/17", pending, now); else passed++;
        evt_ready = 1'b1;
        step(1);
        evt_ready = 1'b0;
    endtask

    task automatic test_prescale_enable();
        cfg_prescale = 16'd3;
        do_reset();
        send_req(2'd0, 1'b0, 1'b0, 32'd4);
        step(15);
        checks++; if (now !== 32'd4 || pending !== 4'b0000)
            $display("[TB] FAIL prescale_early: got now=%0d p=%b want 4/0000", now, pending); else passed++;
        step(1);
        checks++; if (pending !== 4'b0001) $display("[TB] FAIL prescale_fire: got %b want 0001", pending); else passed++;
        do_reset();
        send_req(2'd0, 1'b0, 1'b0, 32'd4);
        cfg_enable = 1'b0;
        step(7);
        cfg_enable = 1'b1;
        checks++; if (now !== 32'd0) $display("[TB] FAIL enable_frozen: got %0d want 0", now); else passed++;
        step(15);
        checks++; if (now !== 32'd4 || pending !== 4'b0000)
            $display("[TB] FAIL enable_early: got now=%0d p=%b want 4/0000", now, pending); else passed++;
        step(1);
        checks++; if (pending !== 4'b0001) $display("[TB] FAIL enable_fire: got %b want 0001", pending); else passed++;
        cfg_prescale = 16'd0;
    endtask

    task automatic test_reset_midrun();
        do_reset();
        send_req(2'd2, 1'b0, 1'b0, 32'd8);
        step(3);
        sys_rst = 1'b1;
        step(1);
        checks++; if (now !== 32'd0 || active !== 4'b0000 || pending !== 4'b0000 || evt_valid !== 1'b0 || req_ready !== 1'b0)
            $display("[TB] FAIL midrun_reset: got now=%0d a=%b p=%b v=%b r=%b want 0/0000/0000/0/0",
                     now, active, pending, evt_valid, req_ready); else passed++;
        sys_rst = 1'b0;
        step(12);
        checks++; if (now !== 32'd12 || pending !== 4'b0000 || evt_valid !== 1'b0)
            $display("[TB] FAIL midrun_no_event: got now=%0d p=%b v=%b want 12/0000/0", now, pending, evt_valid); else passed++;
    endtask

    initial begin
        sys_rst      = 1'b1;
        cfg_enable   = 1'b1;
        cfg_prescale = 16'd0;
        req_valid    = 1'b0;
        req_slot     = '0;
        req_cancel   = 1'b0;
        req_periodic = 1'b0;
        req_delay    = 32'd0;
        evt_ready    = 1'b0;
        test_reset();
        test_oneshot();
        test_wrap();
        test_periodic_overrun();
        test_back_to_back();
        test_cancel_rearm();
        test_prescale_enable();
        test_reset_midrun();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
